// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider with a config handshake and run/pause/stop control.
// Emits one registered tick per (div+1) cycles, with periodic or one-shot operation.
module clk_div_ctrl #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 9
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic             cfg_oneshot,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic             tick,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic [15:0]      tick_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] div_reg;
   logic             oneshot_reg;

   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         cnt         <= '0;
         tick        <= 1'b0;
         tick_cnt    <= '0;
         div_reg     <= WIDTH'(DEFAULT_DIV);
         oneshot_reg <= 1'b0;
      end else begin
         tick <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  div_reg     <= cfg_div;
                  oneshot_reg <= cfg_oneshot;
               end
               if (start) begin
                  state    <= RUN;
                  cnt      <= '0;
                  tick_cnt <= '0;
               end
            end
            RUN: begin
               // stop outranks pause, which outranks the terminal count
               if (stop) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (pause) begin
                  state <= PAUSE;
               end else if (cnt == div_reg) begin
                  cnt  <= '0;
                  tick <= 1'b1;
                  if (tick_cnt != 16'hFFFF)
                     tick_cnt <= tick_cnt + 16'd1;
                  if (oneshot_reg)
                     state <= IDLE;
               end else begin
                  cnt <= cnt + WIDTH'(1);
               end
            end
            PAUSE: begin
               if (stop) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (start) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized control
// traffic, all compared against a period/modulo reference model.
module tb_clk_div_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_oneshot = 1'b0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic         stop = 1'b0;
   logic [W-1:0] cfg_div = '0;
   logic         cfg_ready, tick, busy;
   logic [W-1:0] cnt;
   logic [15:0]  tick_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // reference model: position inside the current period, run/pause flags, config
   longint m_div, m_pos;
   int     m_tc;
   bit     m_busy, m_paused, m_os, m_tick;

   always #5 clk = ~clk;

   clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(9)) dut (
      .clk(clk), .nrst(nrst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .start(start), .pause(pause),
      .stop(stop), .tick(tick), .cnt(cnt), .busy(busy), .tick_cnt(tick_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_div = 9; m_pos = 0; m_tc = 0;
      m_busy = 0; m_paused = 0; m_os = 0; m_tick = 0;
   endtask

   task automatic model_step();
      m_tick = 0;
      if (!m_busy) begin
         if (cfg_valid) begin
            m_div = cfg_div;
            m_os  = cfg_oneshot;
         end
         if (start) begin
            m_busy = 1; m_paused = 0; m_pos = 0; m_tc = 0;
         end
      end else if (stop) begin
         m_busy = 0; m_paused = 0; m_pos = 0;
      end else if (m_paused) begin
         if (start) m_paused = 0;
      end else if (pause) begin
         m_paused = 1;
      end else begin
         m_pos = (m_pos + 1) % (m_div + 1);
         if (m_pos == 0) begin
            m_tick = 1;
            if (m_tc < 65535) m_tc++;
            if (m_os) m_busy = 0;
         end
      end
   endtask

   task automatic compare_model();
      chk("tick", tick, m_tick);
      chk("cnt", cnt, m_pos);
      chk("busy", busy, m_busy);
      chk("cfg_ready", cfg_ready, !m_busy);
      chk("tick_cnt", tick_cnt, m_tc);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic quiet();
      cfg_valid = 0; start = 0; pause = 0; stop = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cnt"}, cnt, 0);
      chk({tag, "_tick"}, tick, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, cfg_ready, 1);
      chk({tag, "_tick_cnt"}, tick_cnt, 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      nrst = 1;
      step();

      // default divider, periodic: ticks 10, 20, 30 edges after start
      start = 1; step(); quiet();
      chk("p_cnt0", cnt, 0);
      for (int i = 1; i <= 30; i++) begin
         step();
         chk("p_tick_at", tick, (i % 10 == 0));
         chk("p_cnt_at", cnt, i % 10);
      end
      stop = 1; step(); quiet();

      // one-shot with handshake in the start cycle
      cfg_valid = 1; cfg_div = 3; cfg_oneshot = 1; start = 1; step(); quiet();
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("os_tick_at", tick, (i == 4));
      end
      chk("os_busy", busy, 0);
      chk("os_ready", cfg_ready, 1);
      chk("os_tick_cnt", tick_cnt, 1);

      // div 0: tick every run cycle, then stop
      cfg_valid = 1; cfg_div = 0; cfg_oneshot = 0; start = 1; step(); quiet();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("d0_tick", tick, 1);
      end
      stop = 1; step(); quiet();
      chk("d0_stop_tick", tick, 0);
      chk("d0_stop_cnt", cnt, 0);
      chk("d0_stop_busy", busy, 0);

      // pause at cnt 5 for three cycles, then resume
      cfg_valid = 1; cfg_div = 7; start = 1; step(); quiet();
      repeat (5) step();
      chk("pz_cnt_before", cnt, 5);
      pause = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pz_hold_cnt", cnt, 5);
         chk("pz_hold_tick", tick, 0);
      end
      pause = 0; start = 1; step(); start = 0;
      chk("pz_resume_cnt", cnt, 5);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("pz_tick_at", tick, (i == 3));
      end
      stop = 1; step(); quiet();

      // pause at terminal count also yields no tick
      cfg_valid = 1; cfg_div = 2; start = 1; step(); quiet();
      repeat (2) step();
      pause = 1; step(); pause = 0;
      chk("pz_term_tick", tick, 0);
      chk("pz_term_cnt", cnt, 2);
      stop = 1; step(); quiet();

      // cfg ignored while running; stop+pause at terminal count
      cfg_valid = 1; cfg_div = 4; start = 1; step(); start = 0;
      cfg_div = 1;
      repeat (4) step();
      chk("sp_cnt_term", cnt, 4);
      cfg_valid = 0; stop = 1; pause = 1; step(); quiet();
      chk("sp_tick", tick, 0);
      chk("sp_busy", busy, 0);
      start = 1; step(); quiet();
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("sp_div_kept_tick", tick, (i == 5));
      end
      stop = 1; step(); quiet();

      // full-range divider: period 2^W
      cfg_valid = 1; cfg_div = '1; start = 1; step(); quiet();
      for (int i = 1; i <= 260; i++) begin
         step();
         chk("max_tick_at", tick, (i == 256));
      end
      stop = 1; step(); quiet();

      // asynchronous reset mid-run at cnt 4
      cfg_valid = 1; cfg_div = 7; start = 1; step(); quiet();
      repeat (4) step();
      chk("ar_cnt_before", cnt, 4);
      #3 nrst = 0;
      #1 check_reset_vals("arst");
      model_reset();
      #2 nrst = 1;
      step();
      start = 1; step(); quiet();
      repeat (12) step();
      stop = 1; step(); quiet();

      // randomized control traffic
      for (int i = 0; i < 600; i++) begin
         cfg_valid   = ($urandom_range(0, 2) == 0);
         cfg_div     = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 6));
         cfg_oneshot = ($urandom_range(0, 3) == 0);
         start       = ($urandom_range(0, 3) == 0);
         pause       = ($urandom_range(0, 5) == 0);
         stop        = ($urandom_range(0, 15) == 0);
         step();
      end
      quiet();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
